// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for one DDS channel.
// Steps the channel frequency word from f_start to f_stop (and back, in triangle mode).
// Each word is held for a programmable dwell. The block also issues the
// phase-accumulator reset pulse.
//
// Ports:
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   cfg_valid/cfg_ready  config handshake; ready only while idle
//   f_start/f_stop/f_step/dwell/mode  sweep configuration, captured into shadow registers
//   start, stop          sweep start strobe / abort strobe
//   freq_ctrl            word driven to the DDS frequency input
//   phase_rst            one-cycle pulse to the DDS phase-accumulator reset
//   busy, dir            sweep in progress, current leg (0 up, 1 down)
//   sweep_done, cfg_err  one-cycle pulses: one-shot completion, rejected start
module dds_sweep_ctrl #(
  parameter int unsigned FW = 32,
  parameter int unsigned DW = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic          stop,
  output logic [FW-1:0] freq_ctrl,
  output logic          phase_rst,
  output logic          busy,
  output logic          dir,
  output logic          sweep_done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {StIdle, StDwell, StStep} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] freq_q, freq_d;
  logic          phase_rst_q, phase_rst_d, busy_q, busy_d, dir_q, dir_d;
  logic          done_q, done_d, err_q, err_d;
  logic [FW-1:0] eff_start, eff_stop, eff_step;

  // Next word on an up leg, clamped to lim; the extra bit catches carry-out.
  function automatic logic [FW-1:0] step_up(input logic [FW-1:0] cur, input logic [FW-1:0] inc,
                                            input logic [FW-1:0] lim);
    logic [FW:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum >= {1'b0, lim}) ? lim : sum[FW-1:0];
  endfunction

  // Next word on a down leg, clamped to lim without ever underflowing.
  function automatic logic [FW-1:0] step_dn(input logic [FW-1:0] cur, input logic [FW-1:0] dec,
                                            input logic [FW-1:0] lim);
    if (cur < dec || (cur - dec) <= lim) return lim;
    return cur - dec;
  endfunction

  assign cfg_ready  = (state_q == StIdle);
  assign freq_ctrl  = freq_q;
  assign phase_rst  = phase_rst_q;
  assign busy       = busy_q;
  assign dir        = dir_q;
  assign sweep_done = done_q;
  assign cfg_err    = err_q;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    freq_d      = freq_q;
    busy_d      = busy_q;
    dir_d       = dir_q;
    phase_rst_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // A start in the handshake cycle sees the values being presented, not the old shadow.
    eff_start = cfg_valid ? f_start : start_q;
    eff_stop  = cfg_valid ? f_stop  : stop_q;
    eff_step  = cfg_valid ? f_step  : step_q;

    if (cfg_valid && cfg_ready) begin
      start_d = f_start;
      stop_d  = f_stop;
      step_d  = f_step;
      dwell_d = dwell;
      mode_d  = mode;
    end

    if (stop && state_q != StIdle) begin
      // Abort wins over any STEP update; freq_ctrl stays frozen.
      state_d = StIdle;
      busy_d  = 1'b0;
      dir_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            if (eff_start > eff_stop || eff_step == '0) begin
              err_d = 1'b1;
            end else begin
              state_d     = StDwell;
              freq_d      = eff_start;
              phase_rst_d = 1'b1;
              busy_d      = 1'b1;
              dir_d       = 1'b0;
              cnt_d       = '0;
            end
          end
        end
        StDwell: begin
          if (cnt_q == dwell_q) state_d = StStep;
          else                  cnt_d   = cnt_q + DW'(1);
        end
        StStep: begin
          state_d = StDwell;
          cnt_d   = '0;
          if (!dir_q) begin
            if (freq_q != stop_q) begin
              freq_d = step_up(freq_q, step_q, stop_q);
            end else if (!mode_q[0] || start_q == stop_q) begin
              // Sawtooth top, or a single-word triangle where top and bottom coincide.
              if (!mode_q[1]) begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else if (!mode_q[0]) begin
                freq_d      = start_q;
                phase_rst_d = 1'b1;
              end
            end else begin
              dir_d  = 1'b1;
              freq_d = step_dn(stop_q, step_q, start_q);
            end
          end else begin
            if (freq_q != start_q) begin
              freq_d = step_dn(freq_q, step_q, start_q);
            end else if (!mode_q[1]) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              dir_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              dir_d  = 1'b0;
              freq_d = step_up(start_q, step_q, stop_q);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      freq_q      <= '0;
      phase_rst_q <= 1'b0;
      busy_q      <= 1'b0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      freq_q      <= freq_d;
      phase_rst_q <= phase_rst_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep scheduler for one DDS channel. It sequences the channel's 32-bit frequency control word (FREQ_CTRL) from a start word to a stop word in fixed steps. Each step is held for a programmable dwell time. It also issues the phase-accumulator reset pulse. One instance sits between the key/config logic and each dds channel's FREQ_CTRL and fre_add_r inputs.

Parameters:
FW, 32, frequency word width (matches dds FREQ_CTRL)
DW, 16, dwell counter width

Ports:
sys_clk  in  1  system clock (24 MHz)
sys_rst  in  1  asynchronous reset, active-high
cfg_valid  in  1  config present; handshake with cfg_ready
cfg_ready  out  1  high only in IDLE
f_start  in  FW  sweep start word
f_stop  in  FW  sweep stop word
f_step  in  FW  step increment
dwell  in  DW  hold each word for dwell+1 cycles
mode  in  2  [0]: 0=sawtooth (up only), 1=triangle (up/down); [1]: 0=one-shot, 1=continuous; sampled with config
start  in  1  sweep start strobe
stop  in  1  abort strobe
freq_ctrl  out  FW  word driven to dds FREQ_CTRL
phase_rst  out  1  one-cycle pulse to dds fre_add_r
busy  out  1  sweep in progress
dir  out  1  0=up leg, 1=down leg
sweep_done  out  1  one-cycle pulse at one-shot completion
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, sys_rst=1): state IDLE. Outputs: freq_ctrl=0, phase_rst=0, busy=0, dir=0, sweep_done=0, cfg_err=0, cfg_ready=1. Shadow config cleared to 0.
- Config handshake:
  - cfg_ready = (state==IDLE). Shadow regs load f_start/f_stop/f_step/dwell/mode at the edge where cfg_valid & cfg_ready.
  - cfg_valid while busy is ignored. There is no queueing.
- Start in IDLE:
  - If cfg handshake occurs in the same cycle, the sweep uses the newly presented values.
  - Otherwise it uses the shadow values.
- Start rejection: if f_start > f_stop (unsigned) or f_step==0, cfg_err pulses at T+1, and state, busy and freq_ctrl are unchanged.
- Accepted start at edge T: at T+1 freq_ctrl=f_start, phase_rst=1 (one cycle), busy=1, dir=0, state DWELL, dwell counter=0.
- start while busy is ignored.
- States: IDLE, DWELL, STEP.
  - DWELL: counter increments each cycle. When counter==dwell, go to STEP.
  - STEP lasts 1 cycle: compute the next word, update freq_ctrl at its exit edge, clear counter, return to DWELL or go to IDLE.
  - Each word is therefore visible for dwell+2 cycles (dwell+1 in DWELL, plus 1 in STEP). Exception: the first word is visible dwell+2 cycles from T+1.
- Step arithmetic: unsigned, FW+1 bits.
  - Up: nxt=cur+f_step. If carry or nxt>=f_stop, use f_stop and end the leg.
  - Down: if cur<f_step or cur-f_step<=f_start, use f_start and end the leg.
  - Endpoints are clamped exactly; words never exceed [f_start, f_stop].
- End-of-leg actions, taken on the STEP after dwelling at the endpoint:
  - Sawtooth one-shot, after f_stop dwell: IDLE, sweep_done=1 for one cycle, busy=0, freq_ctrl holds f_stop.
  - Sawtooth continuous, after f_stop dwell: freq_ctrl=f_start with phase_rst pulse.
  - Triangle, at f_stop: dir=1, next word f_stop-step (clamped). The endpoint is held once, not doubled.
  - Triangle one-shot, after f_start dwell on the down leg: IDLE, sweep_done, freq_ctrl holds f_start, dir=0.
  - Triangle continuous: dir=0, continue up. No phase_rst except at initial start.
- f_start==f_stop: a single-word sweep.
  - One-shot: done after one dwell.
  - Continuous sawtooth: phase_rst repeats every dwell+2 cycles.
- stop in DWELL/STEP: next edge IDLE, busy=0, dir=0, freq_ctrl frozen at its current value, no sweep_done. stop has priority over any simultaneous STEP update.
- stop and start in the same IDLE cycle: stop wins; nothing happens and there is no cfg_err. The cfg handshake in that cycle still loads.
- Reset mid-sweep: immediate return to reset values.
- Shadow config is not disturbed by a sweep. A restart reuses it.

Test Plan:
- Reset values: after sys_rst pulse -> freq_ctrl=0, busy=0, cfg_ready=1; all pulse outputs 0.
- Sawtooth one-shot: f_start=100, f_stop=130, f_step=10, dwell=2, mode=00 -> freq_ctrl 100,110,120,130, each 4 cycles; phase_rst at T+1 only; sweep_done once; busy falls; freq_ctrl holds 130.
- Clamp and triangle continuous: f_start=0, f_stop=25, f_step=10, dwell=0, mode=11 -> sequence 0,10,20,25,15,5,0,10,... with 2 cycles per word; dir toggles at 25 and 0; no further phase_rst.
- Overflow clamp: f_start=0xFFFFFF00, f_stop=0xFFFFFFFF, f_step=0x80, mode=00 -> FF00, FF80, FFFF (upper 24 bits all F); done with no wrap to a small value.
- Rejection and locking:
  - f_start=50, f_stop=40 -> cfg_err pulse, busy stays 0.
  - f_step=0 -> cfg_err.
  - cfg_valid during busy -> cfg_ready=0 and the sweep is unchanged.
- Abort and priority:
  - stop mid-dwell at word 120 -> IDLE next edge, freq_ctrl=120, no sweep_done.
  - stop+start in IDLE -> no action.
  - cfg_valid+start in the same cycle -> sweep starts at the new f_start.
